axis_pkt_gen: RTL
=================

Name: axis_pkt_gen

Overview:
- AXI-Stream transmitter (master) that generates one packet per start request.
- Packet data is an incrementing pattern beginning at a programmable seed; packet length is programmable.
- Drives the slave side of the team's AXI-Stream register slices and sinks. Used as a traffic source in block tests and for link bring-up.
- Fully honours downstream backpressure; a fixed idle gap is inserted between packets.

Parameters:
- DW, 8, data width of m_tdata and seed.
- LW, 8, width of pkt_len; max packet = 2^LW-1 beats.
- GAP, 2, idle cycles after each packet before the next start is accepted; 0 is legal.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request one packet; sampled only in IDLE.
- pkt_len  input  LW  packet length in beats, sampled with an accepted start.
- seed  input  DW  first data value, sampled with an accepted start.
- busy  output  1  high from accepted start until return to IDLE.
- done  output  1  single-cycle pulse when a packet completes.
- pkt_cnt  output  16  completed-packet counter; wraps.
- m_tdata  output  DW  stream data.
- m_tvalid  output  1  stream valid.
- m_tlast  output  1  high on the final beat.
- m_tready  input  1  downstream ready.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0, pkt_cnt=0, internal counters=0. Release is synchronous to clk; the first accepted start is on the first edge with rst_n=1.
- State machine: IDLE -> SEND -> GAP -> IDLE. When GAP=0, SEND goes directly to IDLE.
- IDLE:
  - m_tvalid=0, busy=0.
  - An accepted start requires start=1 and pkt_len!=0. It latches len=pkt_len and data=seed, clears beat=0, and moves to SEND. busy=1 and m_tvalid=1 from the next cycle, so latency start->first valid is 1 cycle.
  - start with pkt_len=0 is ignored: state, counters and done are unchanged.
- SEND:
  - m_tvalid=1, m_tdata=data, m_tlast=(beat==len-1).
  - A handshake is m_tvalid&&m_tready. On a handshake: data<=data+1 (mod 2^DW, wraps silently); beat<=beat+1.
  - Without a handshake, m_tdata, m_tlast and m_tvalid hold stable. m_tvalid never depends on m_tready.
  - On the handshake of the last beat:
    - next cycle m_tvalid=0 and m_tlast=0;
    - done=1 for exactly that one cycle;
    - pkt_cnt increments on the same edge (0xFFFF -> 0x0000);
    - state moves to GAP, or to IDLE if GAP=0.
  - A 1-beat packet asserts m_tlast on its only beat.
  - Throughput is 1 beat per cycle while m_tready=1.
- GAP:
  - m_tvalid=0, busy=1; a counter runs GAP cycles, then IDLE. start is ignored throughout.
- start during SEND or GAP is ignored and not queued. pkt_len and seed changes outside an accepted start have no effect.
- Reset asserted mid-packet aborts it immediately: m_tvalid drops asynchronously, no done pulse, pkt_cnt resets to 0.
- The minimum start-to-start spacing for back-to-back packets is len+GAP+1 cycles with m_tready=1. Each extra cycle of backpressure adds one cycle.

Test Plan:
- Basic packet: reset, start with pkt_len=4, seed=0x10, m_tready=1. Required: m_tvalid rises 1 cycle after start; data 0x10,0x11,0x12,0x13 on consecutive cycles; m_tlast only on 0x13; done pulses once; pkt_cnt=1; busy falls GAP+1 cycles after the last beat.
- Backpressure: pkt_len=3, seed=0x00, m_tready toggling 1,0,0,1,0,1. Required: each beat is held stable while m_tready=0; exactly 0x00,0x01,0x02 are accepted; m_tlast stays stable on 0x02 until accepted.
- Wrap and edge lengths:
  - seed=0xFE, pkt_len=4 (DW=8): required data 0xFE,0xFF,0x00,0x01.
  - pkt_len=1: required a single beat with m_tlast=1.
  - pkt_len=0: required no m_tvalid, no done, pkt_cnt unchanged.
- Ignored start: assert start during SEND and during GAP with new pkt_len/seed. Required: the current packet is unaffected and no second packet is sent; a start after busy=0 sends normally.
- Reset mid-packet: pkt_len=8, deassert rst_n after the 3rd beat. Required: m_tvalid=0 and pkt_cnt=0 immediately, no done. After release, start with pkt_len=2, seed=0x40 gives 0x40,0x41.
- Counter wrap: force or run 65536 packets. Required: pkt_cnt returns 0x0000 and done pulses once per packet.

Source files
------------

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: one incrementing-data packet per accepted start,
// with a fixed idle gap after each packet before the next start is taken.
module axis_pkt_gen #(
    parameter int unsigned DW  = 8,
    parameter int unsigned LW  = 8,
    parameter int unsigned GAP = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] pkt_len,
    input  logic [DW-1:0] seed,
    output logic          busy,
    output logic          done,
    output logic [15:0]   pkt_cnt,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready
);

    localparam int unsigned CW = 16;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [LW-1:0] beat_nxt;
    logic [DW-1:0] data_q, data_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;

    // State and all outputs are registered; next values come from the block below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            beat_q   <= '0;
            data_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            data_q   <= data_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
        end
    end

    assign beat_nxt = beat_q + LW'(1);

    // Next-state logic; tlast is precomputed so it is valid on the beat it marks.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        beat_d   = beat_q;
        data_d   = data_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        gap_d    = gap_q;

        case (state_q)
            S_IDLE: begin
                if (start && (pkt_len != '0)) begin
                    len_d    = pkt_len;
                    data_d   = seed;
                    beat_d   = '0;
                    tvalid_d = 1'b1;
                    tlast_d  = (pkt_len == LW'(1));
                    busy_d   = 1'b1;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                if (m_tready) begin
                    data_d = data_q + DW'(1);
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                        cnt_d    = cnt_q + CW'(1);
                        beat_d   = '0;
                        gap_d    = '0;
                        if (GAP == 0) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        beat_d  = beat_nxt;
                        tlast_d = (beat_nxt == (len_q - LW'(1)));
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pkt_cnt  = cnt_q;
    assign m_tdata  = data_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;

endmodule
